// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative cipher core.
//   - state_t / word_t    : 128-bit cipher state and 32-bit key word
//   - sbox / xtime        : GF(2^8) byte primitives (polynomial 0x11B)
//   - RCON / rcon_of      : round constants, valid indices 1..10
//   - nr_of               : round count for a given key length
//   - sub_word, sub_bytes, shift_rows, mix_columns : round datapath stages
// Byte 0 of a state is bits [127:120]; byte k sits at column k/4, row k%4.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Indices outside 1..10 never reach an AddRoundKey; return zero for them.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] r;
        r = '0;
        if (idx >= 4'd1 && idx <= 4'd10)
            r = RCON[idx];
        return r;
    endfunction

    function automatic int unsigned nr_of(input int unsigned key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t r;
        for (int unsigned i = 0; i < 16; i++)
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // Row r rotates left by r columns.
    function automatic state_t shift_rows(input state_t s);
        state_t r;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned w = 0; w < 4; w++)
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
        return r;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t     r;
        logic [7:0] a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational generation of the next four key-schedule words.
//   i_prev : the four words Nk positions back (w[i-Nk .. i-Nk+3])
//   i_last : the most recent word (w[i-1])
//   i_rcon : round constant applied when i_rot is set
//   i_rot  : 1 = RotWord+SubWord+Rcon, 0 = SubWord only
//   o_next : w[i .. i+3]
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] i_prev,
    input  word_t        i_last,
    input  logic [7:0]   i_rcon,
    input  logic         i_rot,
    output logic [127:0] o_next
);

    word_t w_t, w_n0, w_n1, w_n2, w_n3;

    assign w_t  = i_rot ? (sub_word({i_last[23:0], i_last[31:24]}) ^ {i_rcon, 24'h0})
                        : sub_word(i_last);
    assign w_n0 = i_prev[127:96] ^ w_t;
    assign w_n1 = i_prev[95:64]  ^ w_n0;
    assign w_n2 = i_prev[63:32]  ^ w_n1;
    assign w_n3 = i_prev[31:0]   ^ w_n2;

    assign o_next = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128/256 encryption core, one full round per clock.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : plaintext+key handshake (in_ready follows out_ready in DONE)
//   in_data, in_key     : plaintext and cipher key, byte 0 = MSB byte
//   out_valid/out_ready : ciphertext handshake, out_data held until taken
//   busy                : high while rounds are running
module aes_iter_cipher
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    localparam int unsigned NR = nr_of(KEY_BITS);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_iter_cipher: KEY_BITS must be 128 or 256");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t                r_fsm;
    state_t              r_state;
    logic [KEY_BITS-1:0] r_key;
    logic [3:0]          r_round;
    logic                r_out_valid;
    logic                r_busy;
    state_t              r_out_data;

    logic                w_last_round;
    logic                w_accept;
    logic                w_rot;
    logic [7:0]          w_rcon;
    logic [127:0]        w_key_step;
    logic [127:0]        w_rk;
    logic [KEY_BITS-1:0] w_key_nxt;
    state_t              w_sr;
    state_t              w_res;

    assign w_last_round = (r_round == 4'(NR));
    assign in_ready     = (r_fsm == IDLE) || (r_fsm == DONE && out_ready);
    assign w_accept     = in_valid && in_ready;

    // The upper four held words are always w[i-Nk..]; the lowest is w[i-1].
    aes_key_step u_key_step (
        .i_prev (r_key[KEY_BITS-1 -: 128]),
        .i_last (r_key[31:0]),
        .i_rcon (w_rcon),
        .i_rot  (w_rot),
        .o_next (w_key_step)
    );

    if (KEY_BITS == 256) begin : g_k256
        // Round 1 uses the second key half directly; from round 2 on every round
        // produces four new words, RotWord only when the first word index is a multiple of 8.
        assign w_rot     = ~r_round[0];
        assign w_rcon    = rcon_of({1'b0, r_round[3:1]});
        assign w_rk      = (r_round == 4'd1) ? r_key[127:0] : w_key_step;
        assign w_key_nxt = (r_round == 4'd1) ? r_key : {r_key[127:0], w_key_step};
    end else begin : g_k128
        assign w_rot     = 1'b1;
        assign w_rcon    = rcon_of(r_round);
        assign w_rk      = w_key_step;
        assign w_key_nxt = w_key_step;
    end

    assign w_sr  = shift_rows(sub_bytes(r_state));
    assign w_res = (w_last_round ? w_sr : mix_columns(w_sr)) ^ w_rk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_round     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            // Covers both IDLE and the back-to-back accept out of DONE.
            r_fsm       <= RUN;
            r_state     <= in_data ^ in_key[KEY_BITS-1 -: 128];
            r_key       <= in_key;
            r_round     <= 4'd1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_fsm)
                RUN: begin
                    r_state <= w_res;
                    r_key   <= w_key_nxt;
                    r_round <= r_round + 4'd1;
                    if (w_last_round) begin
                        r_out_data  <= w_res;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Testbench for aes_iter_cipher: one AES-128 and one AES-256 instance share the
// stimulus; sel chooses which one is driven and observed. Expected ciphertexts
// come from FIPS-197 vectors and a byte-array reference cipher whose S-box is
// derived from GF(2^8) inversion and the affine transform.
module tb_aes_iter_cipher;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         sel;
    logic [127:0] in_data;
    logic [255:0] in_key;

    logic         ir128, ov128, busy128;
    logic [127:0] od128;
    logic         ir256, ov256, busy256;
    logic [127:0] od256;

    logic         m_ready, m_valid, m_busy;
    logic [127:0] m_data;

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;

    logic [7:0]   ref_sbox [256];

    always #5 clk = ~clk;

    aes_iter_cipher #(.KEY_BITS(128)) dut128 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel),
        .in_ready  (ir128),
        .in_data   (in_data),
        .in_key    (in_key[255:128]),
        .out_valid (ov128),
        .out_ready (out_ready),
        .out_data  (od128),
        .busy      (busy128)
    );

    aes_iter_cipher #(.KEY_BITS(256)) dut256 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel),
        .in_ready  (ir256),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (ov256),
        .out_ready (out_ready),
        .out_data  (od256),
        .busy      (busy256)
    );

    assign m_ready = sel ? ir256   : ir128;
    assign m_valid = sel ? ov256   : ov128;
    assign m_busy  = sel ? busy256 : busy128;
    assign m_data  = sel ? od256   : od128;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(i), 8'(x)) == 8'h01) inv = 8'(x);
            ref_sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] ref_subw(input logic [31:0] x);
        return {ref_sbox[x[31:24]], ref_sbox[x[23:16]], ref_sbox[x[15:8]], ref_sbox[x[7:0]]};
    endfunction

    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [255:0] key, input int kb);
        int          nk = kb / 32;
        int          nr = nk + 6;
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = ref_subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = ref_subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127 - 8*k -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c + r] ^= w[c][31 - 8*r -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int k = 0; k < 16; k++) s[k] = ref_sbox[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
            for (int k = 0; k < 16; k++) s[k] = t[k];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c + r] ^= w[4*rnd + c][31 - 8*r -: 8];
        end
        for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = s[k];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic s, input logic [127:0] pt, input logic [255:0] key, input bit scramble);
        int unsigned n = 0;
        sel      = s;
        in_data  = pt;
        in_key   = key;
        in_valid = 1'b1;
        #1;
        while (!m_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", 128'(m_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (scramble) begin
            in_data = rand128();
            in_key  = {rand128(), rand128()};
        end
    endtask

    task automatic wait_out(output int unsigned cyc);
        cyc = 1;
        while (!m_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run(input logic s, input logic [127:0] pt, input logic [255:0] key,
                       input logic [127:0] exp, input string tag, input bit scramble);
        int unsigned lat;
        send(s, pt, key, scramble);
        wait_out(lat);
        check({tag, "_lat"}, 128'(lat), s ? 128'd15 : 128'd11);
        check({tag, "_ct"}, m_data, exp);
        @(posedge clk); #1;
        check({tag, "_drop"}, 128'(m_valid), 128'd0);
    endtask

    initial begin
        logic [127:0] pt, d0, exp;
        logic [255:0] key;
        logic         s;
        logic         seen;
        int unsigned  lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = 1'b0;
        in_data   = '0;
        in_key    = '0;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready128", 128'(ir128), 128'd1);
        check("rst_valid128", 128'(ov128), 128'd0);
        check("rst_busy128",  128'(busy128), 128'd0);
        check("rst_data128",  od128, 128'd0);
        check("rst_ready256", 128'(ir256), 128'd1);
        check("rst_valid256", 128'(ov256), 128'd0);
        check("rst_data256",  od256, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 known answers
        send(1'b0, 128'h3243f6a8885a308d313198a2e0370734,
             {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
        check("kat1_busy", 128'(m_busy), 128'd1);
        check("kat1_ready_run", 128'(m_ready), 128'd0);
        wait_out(lat);
        check("kat1_lat", 128'(lat), 128'd11);
        check("kat1_ct", m_data, 128'h3925841d02dc09fbdc118597196a0b32);
        check("kat1_busy_done", 128'(m_busy), 128'd0);
        @(posedge clk); #1;

        run(1'b0, 128'h00112233445566778899aabbccddeeff,
            {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, "kat2", 1'b0);
        run(1'b1, 128'h00112233445566778899aabbccddeeff,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            128'h8ea2b7ca516745bfeafc49904b496089, "kat3", 1'b0);

        // Backpressure in DONE then same-edge accept of the next block
        for (int k = 0; k < 2; k++) begin
            s   = 1'(k);
            pt  = rand128();
            key = {rand128(), rand128()};
            out_ready = 1'b0;
            send(s, pt, key, 1'b0);
            wait_out(lat);
            d0 = m_data;
            check("bp_ct", d0, ref_aes(pt, key, s ? 256 : 128));
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                check("bp_valid", 128'(m_valid), 128'd1);
                check("bp_ready", 128'(m_ready), 128'd0);
                check("bp_hold",  m_data, d0);
            end
            pt  = rand128();
            key = {rand128(), rand128()};
            out_ready = 1'b1;
            #1;
            check("b2b_ready", 128'(m_ready), 128'd1);
            send(s, pt, key, 1'b0);
            wait_out(lat);
            check("b2b_lat", 128'(lat), s ? 128'd15 : 128'd11);
            check("b2b_ct", m_data, ref_aes(pt, key, s ? 256 : 128));
            @(posedge clk); #1;
        end

        // Reset mid-run drops the block
        for (int k = 0; k < 2; k++) begin
            s = 1'(k);
            send(s, rand128(), {rand128(), rand128()}, 1'b0);
            repeat (3) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("mrst_ready", 128'(m_ready), 128'd1);
            check("mrst_valid", 128'(m_valid), 128'd0);
            check("mrst_busy",  128'(m_busy), 128'd0);
            seen = 1'b0;
            repeat (16) begin
                @(posedge clk); #1;
                seen |= m_valid;
            end
            check("mrst_no_out", 128'(seen), 128'd0);
            pt  = rand128();
            key = {rand128(), rand128()};
            run(s, pt, key, ref_aes(pt, key, s ? 256 : 128), "mrst_next", 1'b0);
        end

        // Randomized blocks with inputs scrambled after accept and random sink stalls
        for (int i = 0; i < 12; i++) begin
            s   = 1'($urandom_range(0, 1));
            pt  = rand128();
            key = {rand128(), rand128()};
            exp = ref_aes(pt, key, s ? 256 : 128);
            out_ready = ($urandom_range(0, 1) == 1);
            send(s, pt, key, 1'b1);
            wait_out(lat);
            check("rnd_lat", 128'(lat), s ? 128'd15 : 128'd11);
            check("rnd_ct", m_data, exp);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            check("rnd_hold", m_data, exp);
            out_ready = 1'b1;
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
